apb_slave_ram: RTL and testbench

APB_SLAVE_RAM -- requirements
Module: apb_slave_ram

---
 rtl/apb_slave_ram.sv | 152 +++++++++++++++
 tb/tb_apb_slave_ram.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_ram.sv
// APB word-addressed RAM slave with byte strobes, a configurable number of wait
// states and registered PREADY/PSLVERR/PRDATA.
module apb_slave_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    access_s;
    logic                    in_range_s;
    logic                    mem_we_s;
    logic [IDXW-1:0]         idx_s;
    logic [DATA_WIDTH-1:0]   mem_rd_s;
    logic [DATA_WIDTH-1:0]   mem_wd_s;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Replace only the strobed bytes of a stored word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign in_range_s = (PADDR < ADDR_WIDTH'(DEPTH));
    assign idx_s      = PADDR[IDXW-1:0];
    assign mem_rd_s   = mem_q[idx_s];
    assign mem_wd_s   = merge_bytes(mem_rd_s, PWDATA, PSTRB);

    // Next-state logic: wait-state counting, abort on deselect, one-cycle response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSELx && PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        access_s = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSELx) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    access_s = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response generation; PRDATA holds unless a read completes.
    always_comb begin
        pready_d  = access_s;
        pslverr_d = access_s & ~in_range_s;
        prdata_d  = prdata_q;
        if (access_s && !PWRITE) begin
            if (in_range_s) begin
                prdata_d = mem_rd_s;
            end else begin
                prdata_d = {DATA_WIDTH{1'b0}};
            end
        end else begin
            prdata_d = prdata_q;
        end
    end

    // A reset on the completing edge suppresses the write.
    assign mem_we_s = access_s & PWRITE & in_range_s & ~PRESETn;

    // Control and output registers; PRESETn is an active-high synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Storage array, intentionally not cleared by reset.
    always_ff @(posedge PCLK) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= mem_wd_s;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_ram.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) on a shared bus,
// compared against an array-based reference model of the RAM and responses.
module tb_apb_slave_ram;

    logic              clk;
    logic              presetn;
    logic [2:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0][31:0]  prdata;
    logic [2:0]        pready;
    logic [2:0]        pslverr;

    int checks   = 0;
    int failures = 0;

    int          ws_of [3] = '{0, 2, 3};
    logic [31:0] mdl_mem [3][32];
    logic [31:0] mdl_prdata [3];

    apb_slave_ram #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(clk), .PRESETn(presetn), .PSELx(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );
    apb_slave_ram #(.WAIT_STATES(2)) u_ws2 (
        .PCLK(clk), .PRESETn(presetn), .PSELx(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );
    apb_slave_ram #(.WAIT_STATES(3)) u_ws3 (
        .PCLK(clk), .PRESETn(presetn), .PSELx(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer on slave d with nsetup setup-phase cycles.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input int nsetup);
        int          n;
        bit          done;
        logic [31:0] mask;
        logic        exp_err;
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        for (int i = 0; i < nsetup; i++) begin
            tick();
            check("setup_noready", 32'(pready[d]), 32'd0);
        end
        penable = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n <= ws_of[d] + 4) begin
            tick();
            if (pready[d]) done = 1'b1;
            else n++;
        end
        check("ready_seen", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(ws_of[d]));
        if (a < 32) begin
            exp_err = 1'b0;
            if (wr) begin
                mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
                mdl_mem[d][a] = (mdl_mem[d][a] & ~mask) | (wd & mask);
            end else begin
                mdl_prdata[d] = mdl_mem[d][a];
            end
        end else begin
            exp_err = 1'b1;
            if (!wr) mdl_prdata[d] = 32'd0;
        end
        check("pslverr", 32'(pslverr[d]), 32'(exp_err));
        check("prdata", prdata[d], mdl_prdata[d]);
        tick();
        check("ready_pulse", 32'(pready[d]), 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        presetn = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        pstrb   = 4'h0;
        for (int d = 0; d < 3; d++) mdl_prdata[d] = 32'd0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check("rst_pready", 32'(pready[d]), 32'd0);
            check("rst_pslverr", 32'(pslverr[d]), 32'd0);
            check("rst_prdata", prdata[d], 32'd0);
        end
        presetn = 1'b0;
        tick();

        // Give every word a known value.
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 32; a++)
                xfer(d, 1'b1, 32'(a), $urandom, 4'hF, 1);

        // Full-word write then read, no wait states.
        xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1);
        xfer(0, 1'b0, 32'd5, 32'd0, 4'h0, 1);
        check("deadbeef", prdata[0], 32'hDEADBEEF);

        // Byte strobes.
        xfer(0, 1'b1, 32'd3, 32'h11223344, 4'hF, 1);
        xfer(0, 1'b1, 32'd3, 32'hAABBCCDD, 4'b0101, 1);
        xfer(0, 1'b0, 32'd3, 32'd0, 4'h0, 1);
        check("strobe_merge", prdata[0], 32'h11BB33DD);

        // Zero-strobe write leaves the word alone.
        xfer(0, 1'b1, 32'd9, $urandom, 4'h0, 1);
        xfer(0, 1'b0, 32'd9, 32'd0, 4'h0, 2);

        // Out-of-range accesses, then confirm the whole array survived.
        xfer(0, 1'b1, 32'd40, $urandom, 4'hF, 1);
        xfer(0, 1'b0, 32'd40, 32'd0, 4'h0, 1);
        check("oor_rdata", prdata[0], 32'd0);
        for (int a = 0; a < 32; a++) xfer(0, 1'b0, 32'(a), 32'd0, 4'h0, 1);

        // Three wait states on a read.
        xfer(2, 1'b0, 32'd0, 32'd0, 4'h0, 1);

        // Deselect during the wait phase aborts the write.
        psel    = 3'b010;
        pwrite  = 1'b1;
        paddr   = 32'd4;
        pwdata  = ~mdl_mem[1][4];
        pstrb   = 4'hF;
        penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        check("abort_wait", 32'(pready[1]), 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_noready", 32'(pready[1]), 32'd0);
        end
        xfer(1, 1'b0, 32'd4, 32'd0, 4'h0, 1);

        // Reset during the second wait cycle of a write.
        xfer(2, 1'b1, 32'd7, 32'h5A5A1234, 4'hF, 1);
        xfer(2, 1'b0, 32'd7, 32'd0, 4'h0, 1);
        psel    = 3'b100;
        pwrite  = 1'b1;
        paddr   = 32'd7;
        pwdata  = 32'hCAFEF00D;
        pstrb   = 4'hF;
        penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        tick();
        check("rst_mid_wait", 32'(pready[2]), 32'd0);
        presetn = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) mdl_prdata[d] = 32'd0;
        check("midrst_pready", 32'(pready[2]), 32'd0);
        check("midrst_pslverr", 32'(pslverr[2]), 32'd0);
        check("midrst_prdata", prdata[2], 32'd0);
        presetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        tick();
        xfer(2, 1'b0, 32'd7, 32'd0, 4'h0, 1);
        check("midrst_mem", prdata[2], 32'h5A5A1234);

        // Randomized traffic across all slaves, including out-of-range words.
        for (int i = 0; i < 200; i++) begin
            v = $urandom;
            xfer($urandom_range(0, 2), v[0], 32'($urandom_range(0, 39)), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
